// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned BcdDigW   = 4;
  localparam logic [3:0]  AddThresh = 4'd5;

  // Bit counter must be able to hold the value WIDTH.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_dig_adj.sv
// Double-dabble digit corrector: a digit of 5 or more gets +3 before the shift.
module bcd_dig_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BcdDigW-1:0] dig_i,
  output logic [BcdDigW-1:0] dig_o
);

  // Add-3 correction so the following doubling carries correctly into the next digit.
  always_comb begin
    dig_o = dig_i;
    if (dig_i >= AddThresh) begin
      dig_o = dig_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional macro BCD_OVF_DETECT_EN adds a sticky oOverflow flag for values that
// do not fit in DIGITS decimal digits.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iStart,
  input  logic [WIDTH-1:0]        iBin,
  output logic                    oBusy,
  output logic                    oDone,
`ifdef BCD_OVF_DETECT_EN
  output logic                    oOverflow,
`endif
  output logic [4*DIGITS-1:0]     oBCD
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam int unsigned BcdW = BcdDigW * DIGITS;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   work_q, work_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [BcdW-1:0]   work_adj;
  logic [BcdW-1:0]   work_shift;
  logic              last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_dig_adj u_adj (
      .dig_i (work_q[g*BcdDigW +: BcdDigW]),
      .dig_o (work_adj[g*BcdDigW +: BcdDigW])
    );
  end

  // Top bit of the adjusted work register falls off here; MSB of bin enters digit 0.
  assign work_shift = (work_adj << 1) | BcdW'(bin_q[WIDTH-1]);
  assign last_shift = (cnt_q == CntW'(WIDTH - 1));

  // Next-state and datapath: one bit shifted per SHIFT cycle.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (iStart) begin
          bin_d   = iBin;
          work_d  = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        bin_d  = bin_q << 1;
        work_d = work_shift;
        cnt_d  = cnt_q + 1'b1;
        if (last_shift) begin
          // Result register loads on the edge into DONE so it is valid with oDone.
          bcd_d   = work_shift;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bin_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

`ifdef BCD_OVF_DETECT_EN
  logic ovf_q, ovf_d;
  logic ovf_out_q, ovf_out_d;

  // Sticky loss flag: set whenever the adjusted top digit has its MSB set before a shift.
  always_comb begin
    ovf_d     = ovf_q;
    ovf_out_d = ovf_out_q;
    if (state_q == StIdle && iStart) begin
      ovf_d = 1'b0;
    end else if (state_q == StShift) begin
      ovf_d = ovf_q | work_adj[BcdW-1];
      if (last_shift) begin
        ovf_out_d = ovf_q | work_adj[BcdW-1];
      end
    end
  end

  // Overflow registers, updated alongside the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q     <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign oOverflow = ovf_out_q;
`endif

  assign oBusy = (state_q == StShift);
  assign oDone = (state_q == StDone);
  assign oBCD  = bcd_q;

endmodule
